// File: rtl/sram_arb_pkg.sv
// sram_arb shared types: FSM states, requester ids, bus widths.
// Grant vectors are one-hot with bit order given by the IX_* constants.
package sram_arb_pkg;

    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;

    localparam int IX_VID = 0;
    localparam int IX_LDR = 1;
    localparam int IX_CPU = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        VID,
        LDR,
        CPU
    } req_id_t;

    function automatic req_id_t gnt_to_id(input logic [2:0] gnt);
        req_id_t id;
        id = VID;
        if (gnt[IX_LDR]) id = LDR;
        if (gnt[IX_CPU]) id = CPU;
        return id;
    endfunction

endpackage

// File: rtl/sram_arb_if.sv
// sram_arb bus bundle: three requester ports plus the SRAM pins.
// slave = arbiter side, master = requesters and SRAM device side.
interface sram_arb_if;
    import sram_arb_pkg::*;

    logic  vidReq;
    addr_t vidA;
    data_t vidQ;
    logic  vidAck;

    logic  ldrReq;
    addr_t ldrA;
    data_t ldrD;
    logic  ldrAck;

    logic  cpuReq;
    logic  cpuWe;
    addr_t cpuA;
    data_t cpuD;
    data_t cpuQ;
    logic  cpuAck;

    addr_t sramA;
    data_t sramDo;
    data_t sramDi;
    logic  sramDoe;
    logic  sramOe;
    logic  sramWe;
    logic  sramUb;
    logic  sramLb;

    modport slave (
        input  vidReq, vidA,
        output vidQ, vidAck,
        input  ldrReq, ldrA, ldrD,
        output ldrAck,
        input  cpuReq, cpuWe, cpuA, cpuD,
        output cpuQ, cpuAck,
        output sramA, sramDo, sramDoe,
        output sramOe, sramWe, sramUb, sramLb,
        input  sramDi
    );

    modport master (
        output vidReq, vidA,
        input  vidQ, vidAck,
        output ldrReq, ldrA, ldrD,
        input  ldrAck,
        output cpuReq, cpuWe, cpuA, cpuD,
        input  cpuQ, cpuAck,
        input  sramA, sramDo, sramDoe,
        input  sramOe, sramWe, sramUb, sramLb,
        output sramDi
    );

endinterface

// File: rtl/sram_arb_prio.sv
// sram_arb priority select: video > loader > CPU, except that a
// starved CPU is lifted above the loader (never above video).
module sram_arb_prio
    import sram_arb_pkg::*;
(
    input  logic [2:0] i_req,
    input  logic       i_starve,
    output logic [2:0] o_gnt
);

    // one-hot grant, zero when nothing is requesting
    always_comb begin
        o_gnt = 3'b000;
        if (i_req[IX_VID]) begin
            o_gnt[IX_VID] = 1'b1;
        end else if (i_req[IX_CPU] && i_starve) begin
            o_gnt[IX_CPU] = 1'b1;
        end else if (i_req[IX_LDR]) begin
            o_gnt[IX_LDR] = 1'b1;
        end else if (i_req[IX_CPU]) begin
            o_gnt[IX_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arb.sv
// sram_arb: three-port arbiter for an async 8-bit SRAM (low lane).
// Each transfer is SETUP, ACCESS (1+WAIT_STATES cycles), DONE.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clock,
    input  logic      reset,
    sram_arb_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_t        r_state;
    state_t        w_next;
    req_id_t       r_gnt;
    logic          r_we;
    addr_t         r_addr;
    data_t         r_wdata;
    data_t         r_vidQ;
    data_t         r_cpuQ;
    logic [1:0]    r_wait;
    logic [SW-1:0] r_starve;

    logic [2:0]    w_req;
    logic [2:0]    w_gnt;
    req_id_t       w_gid;
    logic          w_starve;
    logic          w_last;
    logic          w_decide;
    logic          w_busy;

    assign w_req    = {bus.cpuReq, bus.ldrReq, bus.vidReq};
    assign w_starve = (r_starve == SW'(STARVE_LIMIT));
    assign w_last   = (r_wait == 2'(WAIT_STATES));
    assign w_decide = ((r_state == ST_IDLE) || (r_state == ST_DONE))
                      && (|w_req);
    assign w_gid    = gnt_to_id(w_gnt);
    assign w_busy   = (r_state != ST_IDLE);

    sram_arb_prio u_prio (
        .i_req    (w_req),
        .i_starve (w_starve),
        .o_gnt    (w_gnt)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state: DONE chains straight into SETUP when work is waiting
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_decide) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (w_last) w_next = ST_DONE;
            ST_DONE:   w_next = w_decide ? ST_SETUP : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // wait-state counter, only runs while in ACCESS
    always_ff @(posedge clock) begin
        if (reset || (r_state != ST_ACCESS)) begin
            r_wait <= '0;
        end else if (!w_last) begin
            r_wait <= r_wait + 2'd1;
        end
    end

    // latch the winner's request for the whole transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gnt   <= VID;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_decide) begin
            r_gnt <= w_gid;
            unique case (1'b1)
                w_gnt[IX_VID]: begin
                    r_we   <= 1'b0;
                    r_addr <= bus.vidA;
                end
                w_gnt[IX_LDR]: begin
                    r_we    <= 1'b1;
                    r_addr  <= bus.ldrA;
                    r_wdata <= bus.ldrD;
                end
                w_gnt[IX_CPU]: begin
                    r_we    <= bus.cpuWe;
                    r_addr  <= bus.cpuA;
                    r_wdata <= bus.cpuD;
                end
            endcase
        end
    end

    // count CPU pass-overs, saturating at the limit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_decide) begin
            if (w_gnt[IX_CPU]) begin
                r_starve <= '0;
            end else if (bus.cpuReq && !w_starve) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    // read data lands in the port's Q register as DONE ends
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vidQ <= '0;
            r_cpuQ <= '0;
        end else if ((r_state == ST_DONE) && !r_we) begin
            if (r_gnt == VID) r_vidQ <= bus.sramDi;
            if (r_gnt == CPU) r_cpuQ <= bus.sramDi;
        end
    end

    assign bus.vidQ   = r_vidQ;
    assign bus.cpuQ   = r_cpuQ;
    assign bus.vidAck = (r_state == ST_DONE) && (r_gnt == VID);
    assign bus.ldrAck = (r_state == ST_DONE) && (r_gnt == LDR);
    assign bus.cpuAck = (r_state == ST_DONE) && (r_gnt == CPU);

    // WE only in ACCESS so address has a cycle of setup and hold
    assign bus.sramA   = r_addr;
    assign bus.sramDo  = r_wdata;
    assign bus.sramDoe = w_busy && r_we;
    assign bus.sramOe  = !(w_busy && !r_we);
    assign bus.sramWe  = !((r_state == ST_ACCESS) && r_we);
    assign bus.sramUb  = 1'b1;
    assign bus.sramLb  = !w_busy;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed scenarios plus a randomized run against a
// transfer-level model of the arbiter and an SRAM memory model.
module tb_sram_arb;
    import sram_arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    sram_arb_if bus0 ();
    sram_arb_if bus2 ();

    sram_arb #(.WAIT_STATES(0), .STARVE_LIMIT(4)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0.slave)
    );

    sram_arb #(.WAIT_STATES(2), .STARVE_LIMIT(4)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    logic [7:0]  mem0 [4096];
    logic [7:0]  mem2 [4096];
    logic [7:0]  ref_mem [4096];
    logic        pre_en = 1'b0;
    logic [11:0] pre_a = '0;
    logic [7:0]  pre_d = '0;

    bit          p_req [3];
    logic [20:0] p_a [3];
    logic [7:0]  p_d [3];
    bit          p_we [3];

    // SRAM device model: cleared by reset, written while WE is low
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) begin
                mem0[i] <= '0;
                mem2[i] <= '0;
            end
        end else begin
            if (pre_en) mem0[pre_a] <= pre_d;
            if (!bus0.sramWe) mem0[bus0.sramA[11:0]] <= bus0.sramDo;
            if (!bus2.sramWe) mem2[bus2.sramA[11:0]] <= bus2.sramDo;
        end
    end

    // SRAM read data follows the address
    always @(negedge clock) begin
        bus0.sramDi = mem0[bus0.sramA[11:0]];
        bus2.sramDi = mem2[bus2.sramA[11:0]];
    end

    task automatic preset(input logic [11:0] a, input logic [7:0] d);
        pre_a = a;
        pre_d = d;
        pre_en = 1'b1;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_run++;
        if ({bus0.vidAck, bus0.ldrAck, bus0.cpuAck} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_acks got %b want 000",
                     {bus0.vidAck, bus0.ldrAck, bus0.cpuAck});
        end
        n_run++;
        if ({bus0.vidQ, bus0.cpuQ} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_q got %h want 0000",
                     {bus0.vidQ, bus0.cpuQ});
        end
        n_run++;
        if ({bus0.sramOe, bus0.sramWe, bus0.sramUb, bus0.sramLb,
             bus0.sramDoe} !== 5'b11110) begin
            n_fail++;
            $display("FAIL reset_ctl got %b want 11110",
                     {bus0.sramOe, bus0.sramWe, bus0.sramUb,
                      bus0.sramLb, bus0.sramDoe});
        end
        n_run++;
        if (bus0.sramA !== 21'h0 || bus0.sramDo !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_bus got a=%h do=%h want 0/0",
                     bus0.sramA, bus0.sramDo);
        end
        n_run++;
        if ({bus2.sramOe, bus2.sramWe, bus2.sramDoe} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_ctl_ws2 got %b want 110",
                     {bus2.sramOe, bus2.sramWe, bus2.sramDoe});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_cpu_read();
        int lat = 0;
        int oe_lo = 0;
        int we_lo = 0;
        int a_bad = 0;
        preset(12'h123, 8'h5A);
        bus0.cpuWe = 1'b0;
        bus0.cpuA = 21'h00123;
        bus0.cpuReq = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (!bus0.sramOe) oe_lo++;
            if (!bus0.sramWe) we_lo++;
            if (!bus0.sramLb && bus0.sramA !== 21'h00123) a_bad++;
            if (bus0.cpuAck === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus0.cpuReq = 1'b0;
        @(negedge clock);
        if (!bus0.sramOe) oe_lo++;
        n_run++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL rd_latency got %0d want 3", lat);
        end
        n_run++;
        if (oe_lo !== 3) begin
            n_fail++;
            $display("FAIL rd_oe_cycles got %0d want 3", oe_lo);
        end
        n_run++;
        if (we_lo !== 0 || a_bad !== 0) begin
            n_fail++;
            $display("FAIL rd_we_addr got we_lo=%0d a_bad=%0d want 0/0",
                     we_lo, a_bad);
        end
        n_run++;
        if (bus0.cpuQ !== 8'h5A) begin
            n_fail++;
            $display("FAIL rd_cpuQ got %h want 5a", bus0.cpuQ);
        end
        @(negedge clock);
    endtask

    task automatic test_ldr_write();
        int lat = 0;
        int we_lo = 0;
        int doe_ok = 0;
        int a_ok = 0;
        int oe_lo = 0;
        bus0.ldrA = 21'h04000;
        bus0.ldrD = 8'hC3;
        bus0.ldrReq = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (!bus0.sramWe) we_lo++;
            if (!bus0.sramOe) oe_lo++;
            if (bus0.sramDoe && bus0.sramDo === 8'hC3) doe_ok++;
            if (!bus0.sramLb && bus0.sramA === 21'h04000) a_ok++;
            if (bus0.ldrAck === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus0.ldrReq = 1'b0;
        @(negedge clock);
        if (bus0.sramDoe) doe_ok++;
        n_run++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL wr_latency got %0d want 3", lat);
        end
        n_run++;
        if (we_lo !== 1 || oe_lo !== 0) begin
            n_fail++;
            $display("FAIL wr_strobes got we_lo=%0d oe_lo=%0d want 1/0",
                     we_lo, oe_lo);
        end
        n_run++;
        if (doe_ok !== 3 || a_ok !== 3) begin
            n_fail++;
            $display("FAIL wr_drive got doe=%0d addr=%0d want 3/3",
                     doe_ok, a_ok);
        end
        n_run++;
        if (mem0[12'h000] !== 8'hC3) begin
            n_fail++;
            $display("FAIL wr_mem got %h want c3", mem0[12'h000]);
        end
        @(negedge clock);
    endtask

    task automatic test_abandon();
        int lat = 0;
        preset(12'h124, 8'hA7);
        bus0.cpuWe = 1'b0;
        bus0.cpuA = 21'h00124;
        bus0.cpuReq = 1'b1;
        @(negedge clock);
        bus0.cpuReq = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            @(negedge clock);
            if (bus0.cpuAck === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(negedge clock);
        n_run++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL abandon_ack got %0d want 3", lat);
        end
        n_run++;
        if (bus0.cpuQ !== 8'hA7 || bus0.sramLb !== 1'b1) begin
            n_fail++;
            $display("FAIL abandon_q got q=%h lb=%b want a7/1",
                     bus0.cpuQ, bus0.sramLb);
        end
        @(negedge clock);
    endtask

    task automatic test_contention();
        int exp_seq [10] = '{0, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        int got [10];
        int got_n = 0;
        int vage = 0;
        int vmax = 0;
        bit multi = 1'b0;
        logic [2:0] a;
        preset(12'h300, 8'h3C);
        bus0.vidA = 21'h00200;
        bus0.ldrA = 21'h00100;
        bus0.ldrD = 8'h11;
        bus0.cpuA = 21'h00300;
        bus0.cpuWe = 1'b0;
        bus0.vidReq = 1'b1;
        bus0.ldrReq = 1'b1;
        bus0.cpuReq = 1'b1;
        for (int k = 0; k < 80 && got_n < 10; k++) begin
            @(negedge clock);
            if (bus0.vidReq) vage++;
            a = {bus0.cpuAck, bus0.ldrAck, bus0.vidAck};
            if ($countones(a) > 1) multi = 1'b1;
            if (a[0]) begin
                got[got_n] = 0;
                got_n++;
                if (vage > vmax) vmax = vage;
                bus0.vidReq = 1'b0;
            end else if (a[1]) begin
                got[got_n] = 1;
                got_n++;
            end else if (a[2]) begin
                got[got_n] = 2;
                got_n++;
            end
        end
        bus0.vidReq = 1'b0;
        bus0.ldrReq = 1'b0;
        bus0.cpuReq = 1'b0;
        n_run++;
        if (got_n !== 10 || multi) begin
            n_fail++;
            $display("FAIL cont_acks got n=%0d multi=%b want 10/0",
                     got_n, multi);
        end
        for (int i = 0; i < got_n; i++) begin
            n_run++;
            if (got[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL cont_order[%0d] got %0d want %0d",
                         i, got[i], exp_seq[i]);
            end
        end
        n_run++;
        if (vmax > 6 || vmax < 3) begin
            n_fail++;
            $display("FAIL cont_vid_wait got %0d want 3..6", vmax);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_wait_states();
        int lat = 0;
        int we_lo = 0;
        int doe_ok = 0;
        bus2.cpuWe = 1'b1;
        bus2.cpuA = 21'h1ABCD;
        bus2.cpuD = 8'h77;
        bus2.cpuReq = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (!bus2.sramWe) we_lo++;
            if (bus2.sramDoe && bus2.sramDo === 8'h77) doe_ok++;
            if (bus2.cpuAck === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus2.cpuReq = 1'b0;
        @(negedge clock);
        n_run++;
        if (lat !== 5) begin
            n_fail++;
            $display("FAIL ws_latency got %0d want 5", lat);
        end
        n_run++;
        if (we_lo !== 3 || doe_ok !== 5) begin
            n_fail++;
            $display("FAIL ws_strobes got we=%0d doe=%0d want 3/5",
                     we_lo, doe_ok);
        end
        n_run++;
        if (mem2[12'hBCD] !== 8'h77) begin
            n_fail++;
            $display("FAIL ws_mem got %h want 77", mem2[12'hBCD]);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midop();
        int lat = 0;
        bus0.ldrA = 21'h04000;
        bus0.ldrD = 8'h9E;
        bus0.ldrReq = 1'b1;
        repeat (2) @(negedge clock);
        n_run++;
        if (bus0.sramWe !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_access got we=%b want 0", bus0.sramWe);
        end
        reset = 1'b1;
        @(negedge clock);
        n_run++;
        if ({bus0.sramWe, bus0.sramDoe, bus0.ldrAck, bus0.sramLb}
            !== 4'b1001 || bus0.sramA !== 21'h0) begin
            n_fail++;
            $display("FAIL midop_abort got we/doe/ack/lb=%b a=%h want 1001/0",
                     {bus0.sramWe, bus0.sramDoe, bus0.ldrAck, bus0.sramLb},
                     bus0.sramA);
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (bus0.ldrAck === 1'b1) begin
                lat = k;
                break;
            end
        end
        bus0.ldrReq = 1'b0;
        @(negedge clock);
        n_run++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL midop_resume got %0d want 3", lat);
        end
        n_run++;
        if (mem0[12'h000] !== 8'h9E) begin
            n_fail++;
            $display("FAIL midop_mem got %h want 9e", mem0[12'h000]);
        end
        @(negedge clock);
    endtask

    task automatic drive0();
        bus0.vidReq = p_req[0];
        bus0.vidA   = p_a[0];
        bus0.ldrReq = p_req[1];
        bus0.ldrA   = p_a[1];
        bus0.ldrD   = p_d[1];
        bus0.cpuReq = p_req[2];
        bus0.cpuA   = p_a[2];
        bus0.cpuD   = p_d[2];
        bus0.cpuWe  = p_we[2];
    endtask

    task automatic new_req(input int p, inout int vage);
        p_req[p] = 1'b1;
        p_a[p] = 21'h40 + 21'($urandom_range(0, 31));
        p_d[p] = 8'($urandom);
        p_we[p] = (p == 1) ? 1'b1 : (p == 2) ? 1'($urandom) : 1'b0;
        if (p == 0) vage = 0;
    endtask

    // base order video, loader, CPU; a starved CPU beats the loader
    function automatic int pick(input bit v, input bit l, input bit c,
                                input int st);
        if (v) return 0;
        if (c && st >= 4) return 2;
        if (l) return 1;
        return 2;
    endfunction

    task automatic test_random();
        bit m_act = 1'b0;
        int m_cnt = 0;
        int m_g = 0;
        logic [20:0] m_a = '0;
        logic [7:0] m_d = '0;
        bit m_we = 1'b0;
        int m_st = 0;
        logic [7:0] m_vq = '0;
        logic [7:0] m_cq = '0;
        int vage = 0;
        logic [2:0] acks;
        logic [2:0] exp;
        for (int p = 0; p < 3; p++) begin
            p_req[p] = 1'b0;
            p_a[p] = '0;
            p_d[p] = '0;
            p_we[p] = 1'b0;
        end
        foreach (ref_mem[i]) ref_mem[i] = '0;
        drive0();
        pulse_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            acks = {bus0.cpuAck, bus0.ldrAck, bus0.vidAck};
            n_run++;
            if (bus0.vidQ !== m_vq || bus0.cpuQ !== m_cq) begin
                n_fail++;
                $display("FAIL rand_q cyc %0d got %h/%h want %h/%h",
                         cyc, bus0.vidQ, bus0.cpuQ, m_vq, m_cq);
            end
            n_run++;
            if (bus0.sramUb !== 1'b1 || (!bus0.sramOe && !bus0.sramWe)) begin
                n_fail++;
                $display("FAIL rand_ctl cyc %0d got ub/oe/we=%b want 1,not 00",
                         cyc, {bus0.sramUb, bus0.sramOe, bus0.sramWe});
            end
            if (p_req[0]) vage++;
            exp = 3'b000;
            if (m_act) begin
                m_cnt++;
                n_run++;
                if (bus0.sramA !== m_a || bus0.sramLb !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_addr cyc %0d got %h want %h",
                             cyc, bus0.sramA, m_a);
                end
                if (m_cnt == 3) exp[m_g] = 1'b1;
            end
            n_run++;
            if (acks !== exp) begin
                n_fail++;
                $display("FAIL rand_ack cyc %0d got %b want %b",
                         cyc, acks, exp);
            end
            if (m_act && m_cnt == 3) begin
                if (m_we) ref_mem[m_a[11:0]] = m_d;
                else if (m_g == 0) m_vq = ref_mem[m_a[11:0]];
                else m_cq = ref_mem[m_a[11:0]];
                if (m_g == 0) begin
                    n_run++;
                    if (vage > 6) begin
                        n_fail++;
                        $display("FAIL rand_vid_wait got %0d want <=6", vage);
                    end
                end
                m_act = 1'b0;
                if ($urandom_range(0, 1) == 1) new_req(m_g, vage);
                else p_req[m_g] = 1'b0;
            end
            for (int p = 0; p < 3; p++) begin
                if (!p_req[p] && $urandom_range(0, 3) == 0) new_req(p, vage);
            end
            drive0();
            if (!m_act && (p_req[0] || p_req[1] || p_req[2])) begin
                m_g = pick(p_req[0], p_req[1], p_req[2], m_st);
                if (m_g == 2) m_st = 0;
                else if (p_req[2] && m_st < 4) m_st++;
                m_act = 1'b1;
                m_cnt = 0;
                m_a = p_a[m_g];
                m_d = p_d[m_g];
                m_we = p_we[m_g];
            end
        end
        for (int p = 0; p < 3; p++) p_req[p] = 1'b0;
        drive0();
        repeat (5) @(negedge clock);
    endtask

    initial begin
        bus0.vidReq = 1'b0; bus0.vidA = '0;
        bus0.ldrReq = 1'b0; bus0.ldrA = '0; bus0.ldrD = '0;
        bus0.cpuReq = 1'b0; bus0.cpuWe = 1'b0;
        bus0.cpuA = '0; bus0.cpuD = '0;
        bus2.vidReq = 1'b0; bus2.vidA = '0;
        bus2.ldrReq = 1'b0; bus2.ldrA = '0; bus2.ldrD = '0;
        bus2.cpuReq = 1'b0; bus2.cpuWe = 1'b0;
        bus2.cpuA = '0; bus2.cpuD = '0;
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_abandon();
        test_contention();
        test_wait_states();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0: extra ACCESS cycles per transfer (0..3).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive CPU pass-overs before CPU is forced ahead of the loader.
REQ-003 SHALL have a single clock `clock` (in, 1): all logic on rising edge.
REQ-004 SHALL have `reset` (in, 1): synchronous, active-high.
REQ-005 SHALL have video port: vidReq in 1, vidA in 21, vidQ out 8, vidAck out 1; read-only.
REQ-006 SHALL have loader port: ldrReq in 1, ldrA in 21, ldrD in 8, ldrAck out 1; write-only.
REQ-007 SHALL have CPU port: cpuReq in 1, cpuWe in 1, cpuA in 21, cpuD in 8, cpuQ out 8, cpuAck out 1.
REQ-008 SHALL have SRAM side:
- sramA out 21
- sramDo out 8
- sramDi in 8
- sramDoe out 1: drive enable for the top-level tristate
- sramOe, sramWe, sramUb, sramLb out 1 each, active-low

Function
REQ-009 Requests SHALL be level; each requester holds address and data stable until its ack.
- Ack is a 1-cycle pulse.
- A requester holding req high after ack issues a new request.
REQ-010 FSM states SHALL be IDLE, SETUP, ACCESS, DONE.
- IDLE -> SETUP when any request is pending.
- SETUP -> ACCESS after 1 cycle.
- ACCESS lasts 1+WAIT_STATES cycles, then -> DONE.
- DONE -> SETUP if any request is pending, else -> IDLE.
REQ-011 Grant SHALL be decided in IDLE and in DONE, from requests sampled that cycle, and latched for the whole transfer.
REQ-012 Base priority SHALL be video > loader > CPU.
REQ-013 Starvation counter:
- Increments when a CPU request is pending at a grant decision and another requester wins.
- Clears when CPU is granted.
- When it reaches STARVE_LIMIT, CPU SHALL outrank loader but never video.
REQ-014 sramA SHALL carry the granted address from SETUP through DONE.
REQ-015 sramLb SHALL be 0 in SETUP/ACCESS/DONE and 1 in IDLE; sramUb SHALL be 1 always (8-bit low-lane access).
REQ-016 Read transfers:
- sramOe = 0 in SETUP through DONE.
- sramDoe = 0.
- sramDi captured into the granted Q register on the DONE edge.
REQ-017 Write transfers:
- sramDoe = 1 and sramDo = write data in SETUP through DONE.
- sramWe = 0 only in ACCESS cycles, giving address setup and hold of one cycle each.
- sramOe = 1 throughout.
REQ-018 Latency: with WAIT_STATES=0, a request sampled in IDLE at edge n SHALL ack at edge n+3 (ack asserted during DONE); each extra wait state adds one cycle.
REQ-019 vidQ/cpuQ SHALL hold their last value until the next read completion for that port.
REQ-020 Worst-case video wait SHALL be one in-flight transfer: ack within 2*(3+WAIT_STATES) cycles of vidReq.
REQ-021 Back-to-back transfers SHALL have no idle cycle: DONE -> SETUP directly.
REQ-022 A requester dropping req before its ack SHALL NOT abort a granted transfer; the ack is still pulsed and ignored.
REQ-023 Simultaneous requests from all three ports SHALL be served in priority order, one per transfer.
REQ-024 Outside IDLE, sramWe and sramOe SHALL never both be 0.

Reset
REQ-025 While reset is high, on each edge:
- state = IDLE, starvation counter = 0.
- vidAck = ldrAck = cpuAck = 0, vidQ = cpuQ = 0.
- sramOe = sramWe = sramUb = sramLb = 1, sramDoe = 0, sramA = 0, sramDo = 0.
REQ-026 Reset mid-transfer SHALL abort it without ack; the first grant decision follows in the first cycle after reset falls.

Structure
REQ-027 Package sram_arb_pkg SHALL hold:
- state enum
- requester-id enum (VID, LDR, CPU)
- address/data width constants (21, 8)
REQ-028 Priority and starvation selection SHALL be a combinational sub-module sram_arb_prio: requests and starve flag in, one-hot grant out.

Verification
REQ-029 Single CPU read:
- Stimulus: WAIT_STATES=0, cpuReq=1, cpuWe=0, cpuA=0x00123, sramDi=0x5A.
- Required: cpuAck 3 cycles later, cpuQ=0x5A, sramOe low for 3 cycles, sramWe stays 1.
REQ-030 Loader write:
- Stimulus: ldrA=0x04000, ldrD=0xC3.
- Required: sramWe low exactly 1 cycle, sramDoe=1 and sramDo=0xC3 for SETUP..DONE, sramA stable for 3 cycles.
REQ-031 Contention:
- Stimulus: all three requesters held high continuously.
- Required: video granted first, loader starved of nothing, CPU granted on its 5th decision (STARVE_LIMIT=4), video never waits beyond 6 cycles.
REQ-032 Wait states:
- Stimulus: WAIT_STATES=2, single write.
- Required: sramWe low 3 cycles, ack at n+5.
REQ-033 Reset mid-op:
- Stimulus: reset asserted during ACCESS of a write.
- Required: next cycle sramWe=1, sramDoe=0, no ack; normal service after release.
